id_hazard_scoreboard: RTL and testbench
=======================================

Name: id_hazard_scoreboard

Overview:
- Parametrised successor to the decode-stage load-use hazard logic.
- Keeps a per-register scoreboard of in-flight results with configurable latency, so multi-cycle producers (loads, multiply, slow memory) stall dependents for exactly the needed number of cycles.
- Adds a registered interrupt-acceptance FSM that defers IRQs raised in kernel mode until it is safe to take them, and selects which PC is saved as the exception return address.
- Sits in ID, between the decoder and the ID/EX pipeline register.

Parameters:
- ADDR_W, 5: register address width; NREG = 2**ADDR_W scoreboard entries.
- LAT_W, 2: width of each per-register latency counter.
- MAX_LAT, 3: largest legal producer latency; must be ≤ 2**LAT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real (non-bubble) instruction.
- rs_addr  in  ADDR_W  source register 1.
- rt_addr  in  ADDR_W  source register 2.
- rs_used  in  1  instruction reads rs.
- rt_used  in  1  instruction reads rt.
- wr_en  in  1  instruction writes a register.
- wr_addr  in  ADDR_W  destination register.
- wr_lat  in  LAT_W  bubbles required before a dependent may issue (0 = ALU result, forwardable; 1 = load).
- flush  in  1  taken branch/jump resolved in EX; the ID instruction is killed.
- irq  in  1  level-sensitive external interrupt request.
- pc_kernel  in  1  PC[31] of the IF-stage PC.
- pc_id_kernel  in  1  PC[31] of the ID-stage PC.
- stall  out  1  hold IF/ID and insert a bubble into EX.
- pc_write  out  1  PC/IF-ID write enable.
- issue  out  1  ID instruction advances to EX this cycle.
- irq_take  out  1  one-cycle pulse: vector to the handler this cycle.
- irq_pending  out  1  an IRQ is latched and deferred.
- epc_sel  out  2  return-PC source on irq_take: 0 = ID PC, 1 = IF PC, 2 = EX PC.

Behaviour:
- Reset (reset=0, asynchronous):
  - All counters clear to 0 and the FSM goes to IDLE.
  - Outputs: stall=0, pc_write=1, issue=0, irq_take=0, irq_pending=0, epc_sel=0.
- Hazard (combinational):
  - hz = id_valid & ((rs_used & cnt[rs_addr]≠0) | (rt_used & cnt[rt_addr]≠0)).
  - stall = hz & ~irq_take.
  - pc_write = ~stall.
  - issue = id_valid & ~stall & ~flush & ~irq_take.
- Scoreboard update (each cycle):
  - Every nonzero cnt[r] decrements by 1.
  - If issue & wr_en & wr_addr≠0 & wr_lat≠0, then cnt[wr_addr] ← min(wr_lat, MAX_LAT). This set overrides the decrement of the same entry.
  - Entry 0 is never written and always reads 0.
  - wr_lat=0 never sets a counter.
- Latency contract: a producer with wr_lat=L followed immediately by a dependent yields exactly L stall cycles. L=1 reproduces the classic single load-use bubble.
- Stalled or flushed instructions never modify the scoreboard. Counters keep draining during stalls and flushes.
- IRQ FSM, with safe = ~pc_kernel & ~pc_id_kernel:
  - IDLE: irq&safe → TAKE; irq&~safe → PEND.
  - PEND: ~irq → IDLE (request withdrawn); irq&safe → TAKE.
  - TAKE: → IDLE unconditionally. Next cycle pc_kernel=1, so a still-high irq goes to PEND, not a second take.
  - The FSM registers the decision; irq_take = (state==TAKE).
  - irq_pending = (state==PEND).
- epc_sel while irq_take:
  - 2 if flush is high in the same cycle.
  - Otherwise 1 if id_valid=0 (ID is a flush bubble).
  - Otherwise 0.
  - epc_sel=0 when irq_take=0.
- Simultaneous irq_take and hazard: the hazard is suppressed (stall=0, pc_write=1), the ID instruction is not issued, and the scoreboard continues to drain.
- Reset mid-operation: all pending latencies and any deferred IRQ are discarded.

Decomposition:
- Shared package id_pkg:
  - IRQ state encoding (IDLE=2'd0, PEND=2'd1, TAKE=2'd2).
  - EPC_SEL constants (EPC_ID, EPC_IF, EPC_EX).
  - Default ADDR_W/LAT_W.
- One natural sub-module: id_irq_ctrl, containing the FSM plus epc_sel logic. The scoreboard array stays in the top module.

Test Plan:
- Reset: cnt, epc_sel=0, pc_write=1, stall=0.
- Issue load $8 (wr_lat=1), then "add $9,$8,$1" with rs_used=1 → stall=1 for exactly 1 cycle, issue=1 on the next cycle.
- wr_lat=3 producer to $5, dependent next → 3 stall cycles. Repeat with 2 independent instructions between → 1 stall cycle.
- Producer to $0 with wr_lat=3, dependent reads $0 → no stall. wr_lat=0 producer → no stall.
- flush=1 on a stalled producer → cnt unchanged.
- irq=1 with pc_kernel=1 → irq_pending=1 and irq_take=0. Drop pc_kernel → irq_take pulses 1 cycle later, epc_sel=0. irq deasserted while in PEND → IDLE, no take.
- irq while flush=1 and safe → irq_take with epc_sel=2. Pending hazard in the same cycle → stall=0, issue=0.
- Assert reset for 1 cycle mid-stall with cnt=2 and PEND → all cleared, dependent issues without stall.

Source files
------------

// File: rtl/id_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard and IRQ controller.
package id_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned LAT_W_DEF  = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPend = 2'd1,
        StTake = 2'd2
    } irq_state_e;

    localparam logic [1:0] EPC_ID = 2'd0;
    localparam logic [1:0] EPC_IF = 2'd1;
    localparam logic [1:0] EPC_EX = 2'd2;

endpackage

// File: rtl/id_irq_ctrl.sv
// Interrupt-acceptance FSM: defers IRQs raised in kernel mode and selects the
// exception return-PC source on the accepting cycle.
module id_irq_ctrl
    import id_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       irq_i,
    input  logic       pc_kernel_i,
    input  logic       pc_id_kernel_i,
    input  logic       id_valid_i,
    input  logic       flush_i,
    output logic       irq_take_o,
    output logic       irq_pending_o,
    output logic [1:0] epc_sel_o
);

    irq_state_e state_q, state_d;
    logic       safe;

    assign safe = ~pc_kernel_i & ~pc_id_kernel_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (irq_i && safe) begin
                    state_d = StTake;
                end else if (irq_i) begin
                    state_d = StPend;
                end
            end
            StPend: begin
                if (!irq_i) begin
                    state_d = StIdle;
                end else if (safe) begin
                    state_d = StTake;
                end
            end
            StTake:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        irq_take_o    = (state_q == StTake);
        irq_pending_o = (state_q == StPend);
        epc_sel_o     = EPC_ID;
        if (irq_take_o) begin
            // A flush means EX holds the oldest live PC; an ID bubble means IF does.
            if (flush_i) begin
                epc_sel_o = EPC_EX;
            end else if (!id_valid_i) begin
                epc_sel_o = EPC_IF;
            end
        end
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage per-register latency scoreboard: stalls dependents of multi-cycle
// producers for exactly the remaining latency, and hosts the IRQ acceptance FSM.
module id_hazard_scoreboard
    import id_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned LAT_W   = LAT_W_DEF,
    parameter int unsigned MAX_LAT = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic              rs_used_i,
    input  logic              rt_used_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [LAT_W-1:0]  wr_lat_i,
    input  logic              flush_i,
    input  logic              irq_i,
    input  logic              pc_kernel_i,
    input  logic              pc_id_kernel_i,
    output logic              stall_o,
    output logic              pc_write_o,
    output logic              issue_o,
    output logic              irq_take_o,
    output logic              irq_pending_o,
    output logic [1:0]        epc_sel_o
);

    localparam int unsigned      NREG   = 2 ** ADDR_W;
    localparam logic [LAT_W-1:0] MaxLat = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0] cnt_q [NREG];
    logic [LAT_W-1:0] cnt_d [NREG];
    logic [LAT_W-1:0] set_lat;
    logic             hz;
    logic             do_set;

    id_irq_ctrl u_irq_ctrl (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .irq_i          (irq_i),
        .pc_kernel_i    (pc_kernel_i),
        .pc_id_kernel_i (pc_id_kernel_i),
        .id_valid_i     (id_valid_i),
        .flush_i        (flush_i),
        .irq_take_o     (irq_take_o),
        .irq_pending_o  (irq_pending_o),
        .epc_sel_o      (epc_sel_o)
    );

    always_comb begin
        hz = id_valid_i & ((rs_used_i & (cnt_q[rs_addr_i] != '0)) |
                           (rt_used_i & (cnt_q[rt_addr_i] != '0)));
        stall_o    = hz & ~irq_take_o;
        pc_write_o = ~stall_o;
        issue_o    = id_valid_i & ~stall_o & ~flush_i & ~irq_take_o;
        do_set     = issue_o & wr_en_i & (wr_addr_i != '0) & (wr_lat_i != '0);
        set_lat    = (wr_lat_i > MaxLat) ? MaxLat : wr_lat_i;
    end

    // Every live entry drains each cycle; a new producer overrides its own entry.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
            if (do_set && (wr_addr_i == ADDR_W'(r))) begin
                cnt_d[r] = set_lat;
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed self-checking bench for id_hazard_scoreboard.
module tb_id_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       id_valid;
    logic [4:0] rs_addr, rt_addr, wr_addr;
    logic       rs_used, rt_used, wr_en;
    logic [1:0] wr_lat;
    logic       flush, irq, pc_kernel, pc_id_kernel;
    logic       stall, pc_write, issue, irq_take, irq_pending;
    logic [1:0] epc_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_hazard_scoreboard dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .id_valid_i     (id_valid),
        .rs_addr_i      (rs_addr),
        .rt_addr_i      (rt_addr),
        .rs_used_i      (rs_used),
        .rt_used_i      (rt_used),
        .wr_en_i        (wr_en),
        .wr_addr_i      (wr_addr),
        .wr_lat_i       (wr_lat),
        .flush_i        (flush),
        .irq_i          (irq),
        .pc_kernel_i    (pc_kernel),
        .pc_id_kernel_i (pc_id_kernel),
        .stall_o        (stall),
        .pc_write_o     (pc_write),
        .issue_o        (issue),
        .irq_take_o     (irq_take),
        .irq_pending_o  (irq_pending),
        .epc_sel_o      (epc_sel)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic v, input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu, input logic we,
                         input logic [4:0] wa, input logic [1:0] lat);
        id_valid = v; rs_addr = rs; rs_used = rsu; rt_addr = rt; rt_used = rtu;
        wr_en = we; wr_addr = wa; wr_lat = lat;
        #1;
    endtask

    task automatic idle(input int n);
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0);
        flush = 1'b0; irq = 1'b0; pc_kernel = 1'b0; pc_id_kernel = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle(0);
        #2;
        checks++;
        if ({stall, pc_write, issue, irq_take, irq_pending, epc_sel} !== 7'b0100000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0100000",
                     {stall, pc_write, issue, irq_take, irq_pending, epc_sel});
        end
        @(posedge clk); #1;
        rst_ni = 1'b1;
        // Every counter clear: a reader of any register sees no hazard.
        instr(1'b1, 5'd8, 1'b1, 5'd31, 1'b1, 1'b0, 5'd0, 2'd0);
        checks++;
        if (stall !== 1'b0 || issue !== 1'b1) begin
            errors++;
            $display("FAIL reset_cnt_clear got stall=%b issue=%b want stall=0 issue=1",
                     stall, issue);
        end
        idle(1);
    endtask

    task automatic test_load_use();
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 2'd1);
        checks++;
        if (issue !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL load_issue got issue=%b stall=%b want 1 0", issue, stall);
        end
        step();
        instr(1'b1, 5'd8, 1'b1, 5'd1, 1'b1, 1'b1, 5'd9, 2'd0);
        checks++;
        if ({stall, pc_write, issue} !== 3'b100) begin
            errors++;
            $display("FAIL load_use_stall got %b want 100", {stall, pc_write, issue});
        end
        step();
        checks++;
        if ({stall, pc_write, issue} !== 3'b011) begin
            errors++;
            $display("FAIL load_use_release got %b want 011", {stall, pc_write, issue});
        end
        idle(3);
    endtask

    task automatic test_lat3();
        int  n;
        logic done;
        // Back-to-back dependent: 3 stalls.
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 2'd3);
        step();
        n = 0; done = 1'b0;
        instr(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0);
        for (int i = 0; i < 10 && !done; i++) begin
            if (issue) done = 1'b1;
            else begin
                if (stall) n++;
                step();
            end
        end
        checks++;
        if (!done || n != 3) begin
            errors++;
            $display("FAIL lat3_back_to_back got stalls=%0d issued=%b want 3 1", n, done);
        end
        idle(4);
        // Two independent instructions in between: 1 stall.
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 2'd3);
        step();
        instr(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 2'd0);
        step();
        instr(1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 2'd0);
        step();
        n = 0; done = 1'b0;
        instr(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 2'd0);
        for (int i = 0; i < 10 && !done; i++) begin
            if (issue) done = 1'b1;
            else begin
                if (stall) n++;
                step();
            end
        end
        checks++;
        if (!done || n != 1) begin
            errors++;
            $display("FAIL lat3_gap2 got stalls=%0d issued=%b want 1 1", n, done);
        end
        idle(4);
    endtask

    task automatic test_no_set();
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 2'd3);
        step();
        instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 2'd0);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reg0_no_stall got stall=%b want 0", stall);
        end
        step();
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 2'd0);
        step();
        instr(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0);
        checks++;
        if (stall !== 1'b0 || issue !== 1'b1) begin
            errors++;
            $display("FAIL lat0_no_stall got stall=%b issue=%b want 0 1", stall, issue);
        end
        idle(2);
    endtask

    task automatic test_flush();
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 2'd2);
        step();
        // Stalled and flushed producer of $4 must not arm its counter.
        instr(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 2'd3);
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1 || issue !== 1'b0) begin
            errors++;
            $display("FAIL flush_stalled got stall=%b issue=%b want 1 0", stall, issue);
        end
        step();
        flush = 1'b0;
        instr(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0);
        checks++;
        if (stall !== 1'b0 || issue !== 1'b1) begin
            errors++;
            $display("FAIL flush_no_set got stall=%b issue=%b want 0 1", stall, issue);
        end
        // Unstalled but flushed producer also leaves the scoreboard alone.
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd6, 2'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        instr(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_unstalled_no_set got stall=%b want 0", stall);
        end
        idle(3);
    endtask

    task automatic test_irq_defer();
        irq = 1'b1; pc_kernel = 1'b1;
        step();
        checks++;
        if (irq_pending !== 1'b1 || irq_take !== 1'b0) begin
            errors++;
            $display("FAIL irq_kernel_pend got pend=%b take=%b want 1 0", irq_pending, irq_take);
        end
        pc_kernel = 1'b0;
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0);
        checks++;
        if (irq_take !== 1'b0) begin
            errors++;
            $display("FAIL irq_take_early got take=%b want 0", irq_take);
        end
        step();
        checks++;
        if ({irq_take, irq_pending, epc_sel, issue} !== 5'b10000) begin
            errors++;
            $display("FAIL irq_take_id got %b want 10000",
                     {irq_take, irq_pending, epc_sel, issue});
        end
        // Handler fetch is kernel: still-high irq pends rather than retaking.
        pc_kernel = 1'b1;
        step();
        checks++;
        if (irq_take !== 1'b0 || irq_pending !== 1'b0) begin
            errors++;
            $display("FAIL irq_after_take got take=%b pend=%b want 0 0", irq_take, irq_pending);
        end
        step();
        checks++;
        if (irq_pending !== 1'b1) begin
            errors++;
            $display("FAIL irq_repend got pend=%b want 1", irq_pending);
        end
        irq = 1'b0;
        step();
        checks++;
        if (irq_pending !== 1'b0 || irq_take !== 1'b0) begin
            errors++;
            $display("FAIL irq_withdraw got pend=%b take=%b want 0 0", irq_pending, irq_take);
        end
        pc_kernel = 1'b0;
        step();
        checks++;
        if (irq_take !== 1'b0) begin
            errors++;
            $display("FAIL irq_no_take_after_withdraw got take=%b want 0", irq_take);
        end
        // Take with an ID bubble returns to the IF PC.
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0);
        irq = 1'b1;
        step();
        irq = 1'b0;
        #1;
        checks++;
        if (irq_take !== 1'b1 || epc_sel !== 2'd1) begin
            errors++;
            $display("FAIL irq_take_if got take=%b epc=%0d want 1 1", irq_take, epc_sel);
        end
        idle(2);
    endtask

    task automatic test_irq_flush_hazard();
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10, 2'd3);
        step();
        instr(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, 2'd3);
        irq = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL irq_pre_stall got stall=%b want 1", stall);
        end
        step();
        irq = 1'b0; flush = 1'b1;
        #1;
        checks++;
        if ({irq_take, epc_sel, stall, pc_write, issue} !== 6'b110010) begin
            errors++;
            $display("FAIL irq_take_flush_hazard got %b want 110010",
                     {irq_take, epc_sel, stall, pc_write, issue});
        end
        step();
        flush = 1'b0;
        #1;
        // cnt[10]: 3 -> 2 -> 1, still draining through the take.
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL irq_drain_stall got stall=%b want 1", stall);
        end
        step();
        checks++;
        if (stall !== 1'b0 || issue !== 1'b1) begin
            errors++;
            $display("FAIL irq_drain_release got stall=%b issue=%b want 0 1", stall, issue);
        end
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0);
        step();
        // Producer of $11 never issued, so it must not stall.
        instr(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL irq_unissued_no_set got stall=%b want 0", stall);
        end
        idle(4);
    endtask

    task automatic test_reset_mid();
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 2'd3);
        step();
        instr(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0);
        irq = 1'b1; pc_kernel = 1'b1;
        step();
        checks++;
        if (stall !== 1'b1 || irq_pending !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup got stall=%b pend=%b want 1 1", stall, irq_pending);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || irq_pending !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async got stall=%b pend=%b want 0 0", stall, irq_pending);
        end
        irq = 1'b0; pc_kernel = 1'b0;
        step();
        rst_ni = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || issue !== 1'b1 || irq_pending !== 1'b0) begin
            errors++;
            $display("FAIL mid_after_reset got stall=%b issue=%b pend=%b want 0 1 0",
                     stall, issue, irq_pending);
        end
        step();
        checks++;
        if (irq_take !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_take got take=%b want 0", irq_take);
        end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_lat3();
        test_no_set();
        test_flush();
        test_irq_defer();
        test_irq_flush_hazard();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
